// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register-file writeback arbiter slice.
//   DATA_W / NREG / REG_W : default widths (REG_W == clog2(NREG))
//   REQ_ALU / REQ_LSU     : requester indices, also the encoding of the
//                           round-robin pointer
//   wb_req_t              : one writeback request (valid, destination, data)
// -----------------------------------------------------------------------------
package regfile_pkg;

   localparam int DATA_W = 32;
   localparam int NREG   = 32;
   localparam int REG_W  = 5;

   localparam int REQ_ALU = 0;
   localparam int REQ_LSU = 1;

   typedef struct packed {
      logic              valid;
      logic [REG_W-1:0]  dst;
      logic [DATA_W-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Bundles the two writeback request channels, the decode reservation port,
// the register-file write port and the busy scoreboard.
//   slave  : the arbiter side (consumes requests, drives ready/write/busy)
//   master : the producer/decode/register-file side
// -----------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int NREG   = 32,
   parameter int REG_W  = 5
);

   logic              req0_valid;
   logic [REG_W-1:0]  req0_reg;
   logic [DATA_W-1:0] req0_data;
   logic              req0_ready;

   logic              req1_valid;
   logic [REG_W-1:0]  req1_reg;
   logic [DATA_W-1:0] req1_data;
   logic              req1_ready;

   logic              reserve_en;
   logic [REG_W-1:0]  reserve_reg;

   logic              write_en;
   logic [REG_W-1:0]  write_reg;
   logic [DATA_W-1:0] write_data;

   logic [NREG-1:0]   busy;

   modport slave (
      input  req0_valid, req0_reg, req0_data,
      output req0_ready,
      input  req1_valid, req1_reg, req1_data,
      output req1_ready,
      input  reserve_en, reserve_reg,
      output write_en, write_reg, write_data,
      output busy
   );

   modport master (
      output req0_valid, req0_reg, req0_data,
      input  req0_ready,
      output req1_valid, req1_reg, req1_data,
      input  req1_ready,
      output reserve_en, reserve_reg,
      input  write_en, write_reg, write_data,
      input  busy
   );

endinterface

// File: rtl/wb_scoreboard.sv
// -----------------------------------------------------------------------------
// wb_scoreboard
// Per-register busy vector used by decode for hazard stalls.
//   clk, rst          : clock, asynchronous active-high reset
//   set_en, set_reg   : reserve a destination register (decode issue)
//   clr_en, clr_reg   : clear on an accepted writeback
//   busy              : bit n = 1 while register n has a write pending
// Only exists when REGFILE_SCOREBOARD_EN is defined; the arbiter ties busy to
// zero otherwise.
// -----------------------------------------------------------------------------
`ifdef REGFILE_SCOREBOARD_EN
module wb_scoreboard #(
   parameter int NREG  = 32,
   parameter int REG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             set_en,
   input  logic [REG_W-1:0] set_reg,
   input  logic             clr_en,
   input  logic [REG_W-1:0] clr_reg,
   output logic [NREG-1:0]  busy
);

   logic [NREG-1:0] set_mask;
   logic [NREG-1:0] clr_mask;
   logic [NREG-1:0] busy_q;

   // Register 0 is hardwired, so neither mask may ever address it; that keeps
   // busy[0] permanently 0.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (set_en && (set_reg != '0)) set_mask = NREG'(1) << set_reg;
      if (clr_en && (clr_reg != '0)) clr_mask = NREG'(1) << clr_reg;
   end

   // Set is applied after clear: a same-edge reserve means a newer producer
   // is already in flight, so the bit must stay pending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy_q <= '0;
      else     busy_q <= (busy_q & ~clr_mask) | set_mask;
   end

   assign busy = busy_q;

endmodule
`endif

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the register-file write port between the ALU (req0) and the LSU
// (req1) with round-robin arbitration, registers the winning write and keeps
// a busy scoreboard for decode.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : regfile_wb_arbiter_if.slave
//              req0_*/req1_* valid/ready request channels, reserve_en/_reg,
//              write_en/_reg/_data register-file port, busy scoreboard
// Configuration macro: REGFILE_SCOREBOARD_EN builds the scoreboard; without it
// busy is tied to 0 and the reservation port is ignored.
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
   parameter int DATA_W = regfile_pkg::DATA_W,
   parameter int NREG   = regfile_pkg::NREG,
   parameter int REG_W  = regfile_pkg::REG_W
) (
   input  logic                 clk,
   input  logic                 rst,
   regfile_wb_arbiter_if.slave  bus
);

   import regfile_pkg::*;

   wb_req_t           req0;
   wb_req_t           req1;
   wb_req_t           win;
   logic              contended;
   logic              same_reg;
   logic              grant0;
   logic              grant1;
   logic              ptr;
   logic              write_en_q;
   logic [REG_W-1:0]  write_reg_q;
   logic [DATA_W-1:0] write_data_q;
   logic [NREG-1:0]   busy_vec;

   assign req0 = '{valid: bus.req0_valid, dst: bus.req0_reg, data: bus.req0_data};
   assign req1 = '{valid: bus.req1_valid, dst: bus.req1_reg, data: bus.req1_data};

   // Grant selection. A same nonzero destination forces the LSU first so the
   // older result cannot overwrite the younger ALU result.
   always_comb begin
      contended = req0.valid && req1.valid;
      same_reg  = contended && (req0.dst == req1.dst) && (req0.dst != '0);
      grant1    = req1.valid && (!req0.valid || same_reg || (ptr == 1'(REQ_LSU)));
      grant0    = req0.valid && !grant1;
      win       = grant1 ? req1 : req0;
      win.valid = grant0 || grant1;
   end

   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;

   // Pointer moves only on an ordinary contended grant. Writes to x0 are
   // accepted but never strobed; reg/data hold when nothing is granted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr          <= 1'(REQ_ALU);
         write_en_q   <= 1'b0;
         write_reg_q  <= '0;
         write_data_q <= '0;
      end else begin
         if (contended && !same_reg)
            ptr <= grant0 ? 1'(REQ_LSU) : 1'(REQ_ALU);
         write_en_q <= win.valid && (win.dst != '0);
         if (win.valid) begin
            write_reg_q  <= win.dst;
            write_data_q <= win.data;
         end
      end
   end

   assign bus.write_en   = write_en_q;
   assign bus.write_reg  = write_reg_q;
   assign bus.write_data = write_data_q;

`ifdef REGFILE_SCOREBOARD_EN
   wb_scoreboard #(
      .NREG  (NREG),
      .REG_W (REG_W)
   ) u_scoreboard (
      .clk     (clk),
      .rst     (rst),
      .set_en  (bus.reserve_en),
      .set_reg (bus.reserve_reg),
      .clr_en  (win.valid),
      .clr_reg (win.dst),
      .busy    (busy_vec)
   );
`else
   logic unused_reserve;
   assign unused_reserve = ^{bus.reserve_en, bus.reserve_reg};
   assign busy_vec = '0;
`endif

   assign bus.busy = busy_vec;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Self-checking bench for regfile_wb_arbiter: a rule-level model checked every
// cycle plus hand-computed literal expectations for the directed scenarios.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;

   localparam int DATA_W = 32;
   localparam int NREG   = 32;
   localparam int REG_W  = 5;
   localparam bit SB_EN  =
`ifdef REGFILE_SCOREBOARD_EN
      1'b1;
`else
      1'b0;
`endif

   logic clk;
   logic rst;
   int   compared;
   int   mismatched;

   regfile_wb_arbiter_if #(.DATA_W(DATA_W), .NREG(NREG), .REG_W(REG_W)) bus ();

   regfile_wb_arbiter #(.DATA_W(DATA_W), .NREG(NREG), .REG_W(REG_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state: which requester wins a plain tie, the expected write port
   // and the expected set of pending registers.
   int                mPref;
   logic              mWe;
   logic [REG_W-1:0]  mWreg;
   logic [DATA_W-1:0] mWdata;
   logic [NREG-1:0]   mBusy;

   // Rules: a lone requester wins; equal nonzero destinations go to the LSU;
   // otherwise the favoured one wins. Returns -1 when nobody asks.
   function automatic int modelWinner(input logic v0, input logic [REG_W-1:0] r0,
                                      input logic v1, input logic [REG_W-1:0] r1,
                                      input int pref);
      if (v0 && !v1) return 0;
      if (v1 && !v0) return 1;
      if (!v0 && !v1) return -1;
      if (r0 == r1 && r0 != 0) return 1;
      return pref;
   endfunction

   function automatic logic [NREG-1:0] modelBusy(input logic [NREG-1:0] cur, input int w,
                                                 input logic [REG_W-1:0] wreg,
                                                 input logic ren, input logic [REG_W-1:0] rreg);
      logic [NREG-1:0] b;
      b = cur;
      if (!SB_EN) return '0;
      if (w >= 0 && wreg != 0) b[wreg] = 1'b0;
      if (ren && rreg != 0) b[rreg] = 1'b1;
      return b;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mPref  <= 0;
         mWe    <= 1'b0;
         mWreg  <= '0;
         mWdata <= '0;
         mBusy  <= '0;
      end else begin
         case (modelWinner(bus.req0_valid, bus.req0_reg, bus.req1_valid, bus.req1_reg, mPref))
            0: begin
               mWe    <= (bus.req0_reg != 0);
               mWreg  <= bus.req0_reg;
               mWdata <= bus.req0_data;
               mBusy  <= modelBusy(mBusy, 0, bus.req0_reg, bus.reserve_en, bus.reserve_reg);
               if (bus.req1_valid) mPref <= 1;
            end
            1: begin
               mWe    <= (bus.req1_reg != 0);
               mWreg  <= bus.req1_reg;
               mWdata <= bus.req1_data;
               mBusy  <= modelBusy(mBusy, 1, bus.req1_reg, bus.reserve_en, bus.reserve_reg);
               if (bus.req0_valid && !(bus.req0_reg == bus.req1_reg && bus.req0_reg != 0))
                  mPref <= 0;
            end
            default: begin
               mWe   <= 1'b0;
               mBusy <= modelBusy(mBusy, -1, '0, bus.reserve_en, bus.reserve_reg);
            end
         endcase
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         int w;
         w = modelWinner(bus.req0_valid, bus.req0_reg, bus.req1_valid, bus.req1_reg, mPref);
         checkOutput("model req0_ready", 64'(bus.req0_ready), 64'(w == 0));
         checkOutput("model req1_ready", 64'(bus.req1_ready), 64'(w == 1));
         checkOutput("model write_en", 64'(bus.write_en), 64'(mWe));
         if (mWe) begin
            checkOutput("model write_reg", 64'(bus.write_reg), 64'(mWreg));
            checkOutput("model write_data", 64'(bus.write_data), 64'(mWdata));
         end
         checkOutput("model busy", 64'(bus.busy), 64'(mBusy));
      end
   end

   task automatic applyStimulus(input logic v0, input logic [REG_W-1:0] r0, input logic [DATA_W-1:0] d0,
                                input logic v1, input logic [REG_W-1:0] r1, input logic [DATA_W-1:0] d1,
                                input logic ren, input logic [REG_W-1:0] rreg);
      bus.req0_valid  = v0;
      bus.req0_reg    = r0;
      bus.req0_data   = d0;
      bus.req1_valid  = v1;
      bus.req1_reg    = r1;
      bus.req1_data   = d1;
      bus.reserve_en  = ren;
      bus.reserve_reg = rreg;
      #2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] expReady0;
      logic [REG_W-1:0] expReg;
      compared   = 0;
      mismatched = 0;
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      checkOutput("reset write_en", 64'(bus.write_en), 64'd0);
      checkOutput("reset write_reg", 64'(bus.write_reg), 64'd0);
      checkOutput("reset write_data", 64'(bus.write_data), 64'd0);
      checkOutput("reset busy", 64'(bus.busy), 64'd0);

      // Single requester
      applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
      checkOutput("single ready0", 64'(bus.req0_ready), 64'd1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("single write_en", 64'(bus.write_en), 64'd1);
      checkOutput("single write_reg", 64'(bus.write_reg), 64'd5);
      checkOutput("single write_data", 64'(bus.write_data), 64'hDEADBEEF);
      tick();
      checkOutput("single write_en drop", 64'(bus.write_en), 64'd0);

      // Contention: alternating grants starting with req0
      expReady0 = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 1, 32'h11, 1, 2, 32'h22, 0, 0);
         checkOutput("rr ready0", 64'(bus.req0_ready), 64'(expReady0[i]));
         tick();
         expReg = expReady0[i] ? 5'd1 : 5'd2;
         checkOutput("rr write_en", 64'(bus.write_en), 64'd1);
         checkOutput("rr write_reg", 64'(bus.write_reg), 64'(expReg));
      end

      // Same destination: LSU first, pointer left alone
      applyStimulus(1, 7, 32'd1, 1, 7, 32'd2, 0, 0);
      checkOutput("same ready1", 64'(bus.req1_ready), 64'd1);
      tick();
      applyStimulus(1, 7, 32'd1, 0, 0, 0, 0, 0);
      checkOutput("same first data", 64'(bus.write_data), 64'd2);
      tick();
      checkOutput("same second data", 64'(bus.write_data), 64'd1);
      applyStimulus(1, 1, 32'h11, 1, 2, 32'h22, 0, 0);
      checkOutput("same ptr kept ready0", 64'(bus.req0_ready), 64'd1);
      tick();

      // x0 write and x0 reservation
      applyStimulus(1, 0, 32'hAB, 0, 0, 0, 1, 0);
      checkOutput("x0 ready0", 64'(bus.req0_ready), 64'd1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("x0 write_en", 64'(bus.write_en), 64'd0);
      checkOutput("x0 busy", 64'(bus.busy), 64'd0);

      // Scoreboard: reserve wins over same-edge clear; normal clear later
      applyStimulus(1, 3, 32'h33, 0, 0, 0, 1, 3);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 4);
      checkOutput("race busy3", 64'(bus.busy[3]), 64'(SB_EN));
      tick();
      applyStimulus(0, 0, 0, 1, 4, 32'h44, 0, 0);
      checkOutput("reserve busy4", 64'(bus.busy[4]), 64'(SB_EN));
      checkOutput("lsu ready1", 64'(bus.req1_ready), 64'd1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("clear busy4", 64'(bus.busy[4]), 64'd0);
      checkOutput("clear write_reg", 64'(bus.write_reg), 64'd4);
      tick();

      // Reset in the middle of a registered write (pointer currently favours req1)
      applyStimulus(1, 9, 32'h99, 0, 0, 0, 0, 0);
      tick();
      checkOutput("prerst write_en", 64'(bus.write_en), 64'd1);
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("rst write_en", 64'(bus.write_en), 64'd0);
      checkOutput("rst busy", 64'(bus.busy), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      applyStimulus(1, 1, 32'h11, 1, 2, 32'h22, 0, 0);
      checkOutput("postrst ready0", 64'(bus.req0_ready), 64'd1);
      checkOutput("postrst ready1", 64'(bus.req1_ready), 64'd0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("postrst write_reg", 64'(bus.write_reg), 64'd1);
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
